// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and serial-line bundle between a producer and uart_tx_shift
//   tx_data  [7:0] producer -> tx  byte to send, sampled on the accept cycle
//   tx_valid       producer -> tx  tx_data is valid
//   tx_ready       tx -> producer  transmitter can accept a byte this cycle
//   tx_line        tx -> line      registered serial output, idle/mark = 1
//   tx_busy        tx -> producer  frame in progress
//   tx_done        tx -> producer  one-cycle pulse when a frame has fully gone out
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_line;
    logic       tx_busy;
    logic       tx_done;
    modport master (output tx_data, tx_valid, input tx_ready, tx_line, tx_busy, tx_done);
    modport slave (input tx_data, tx_valid, output tx_ready, tx_line, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_shift.sv
// uart_tx_shift: soft UART transmitter, 8N1 frame (start, d0..d7 LSB first, stop) from a PISO shift register
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   io_tx      uart_tx_if.slave: tx_data/tx_valid in, tx_ready/tx_line/tx_busy/tx_done out
//   BAUD_TICK  clock cycles per bit period (>= 2)
//   PARITY_ODD parity sense when parity is enabled: 0 = even, 1 = odd
//   Define UART_TX_PARITY_EN to insert a parity bit between d7 and the stop bit.
module uart_tx_shift #(
    parameter int BAUD_TICK  = 5208,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic      clk,
    input logic      rst,
    uart_tx_if.slave io_tx
);
    localparam int BW = $clog2(BAUD_TICK);
    localparam logic [BW-1:0] LAST = BW'(BAUD_TICK - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t        r_state, w_state, w_after_data;
    logic [BW-1:0] r_baud, w_baud;
    logic [2:0]    r_bit, w_bit;
    logic [8:0]    r_shift, w_shift;
    logic          r_line, w_line, r_busy, w_busy, r_done, w_done;
    logic          w_tick;
`ifdef UART_TX_PARITY_EN
    assign w_after_data = PARITY;
`else
    assign w_after_data = STOP;
`endif
    assign w_tick = (r_baud == LAST);
    // The parity bit rides above the data byte, so after eight right shifts it sits at bit 0.
    always_comb begin
        w_state = r_state;
        w_baud  = (r_state == IDLE || w_tick) ? '0 : r_baud + 1'b1;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_line  = r_line;
        w_busy  = r_busy;
        w_done  = 1'b0;
        case (r_state)
            IDLE: if (io_tx.tx_valid) begin
                w_state = START;
                w_shift = {^io_tx.tx_data ^ PARITY_ODD, io_tx.tx_data};
                w_line  = 1'b0;
                w_busy  = 1'b1;
                w_bit   = '0;
            end
            START: if (w_tick) begin
                w_state = DATA;
                w_line  = r_shift[0];
            end
            DATA: if (w_tick) begin
                w_shift = r_shift >> 1;
                w_bit   = r_bit + 1'b1;
                w_state = (r_bit == 3'd7) ? w_after_data : DATA;
                w_line  = (r_bit == 3'd7 && w_after_data == STOP) ? 1'b1 : r_shift[1];
            end
            PARITY: if (w_tick) begin
                w_state = STOP;
                w_line  = 1'b1;
            end
            STOP: if (w_tick) begin
                w_state = IDLE;
                w_busy  = 1'b0;
                w_done  = 1'b1;
            end
            default: w_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_line  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_baud  <= w_baud;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_line  <= w_line;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end
    assign io_tx.tx_ready = (r_state == IDLE);
    assign io_tx.tx_line  = r_line;
    assign io_tx.tx_busy  = r_busy;
    assign io_tx.tx_done  = r_done;
endmodule

// File: tb/tb_uart_tx_shift.sv
// tb_uart_tx_shift: self-checking bench for uart_tx_shift with BAUD_TICK=4 (parity variant via UART_TX_PARITY_EN)
module tb_uart_tx_shift;
    localparam int B    = 4;
    localparam bit PODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    uart_tx_if bus();
    uart_tx_shift #(.BAUD_TICK(B), .PARITY_ODD(PODD)) dut (.clk(clk), .rst(rst), .io_tx(bus));

    // Expected line level for each bit period of a frame, bit period 0 = start bit.
    function automatic logic [NB-1:0] frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, (^b) ^ PODD, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_line", bus.tx_line, 1'b1);
            chk("idle_ready", bus.tx_ready, 1'b1);
            chk("idle_busy", bus.tx_busy, 1'b0);
            chk("idle_done", bus.tx_done, 1'b0);
        end
    endtask

    task automatic start(input logic [7:0] b);
        @(negedge clk);
        chk("accept_ready", bus.tx_ready, 1'b1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    // Called just after the accept edge; returns on the tx_done cycle.
    task automatic check_frame(input logic [7:0] b, input bit poke);
        logic [NB-1:0] f;
        f = frame(b);
        for (int c = 0; c < NB * B; c++) begin
            @(negedge clk);
            chk($sformatf("line_%02h_c%0d", b, c), bus.tx_line, f[c / B]);
            if (c % B == 0) begin
                chk($sformatf("busy_%02h_c%0d", b, c), bus.tx_busy, 1'b1);
                chk($sformatf("ready_%02h_c%0d", b, c), bus.tx_ready, 1'b0);
                chk($sformatf("done_%02h_c%0d", b, c), bus.tx_done, 1'b0);
            end
            if (poke && (c == B * 3 + 1 || c == B * 7)) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'($urandom);
            end
            if (poke && (c == B * 3 + 2 || c == B * 7 + 1)) bus.tx_valid = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("end_done_%02h", b), bus.tx_done, 1'b1);
        chk($sformatf("end_ready_%02h", b), bus.tx_ready, 1'b1);
        chk($sformatf("end_busy_%02h", b), bus.tx_busy, 1'b0);
        chk($sformatf("end_line_%02h", b), bus.tx_line, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [7:0] r;
        logic [7:0] s;
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_line", bus.tx_line, 1'b1);
        chk("rst_ready", bus.tx_ready, 1'b1);
        chk("rst_busy", bus.tx_busy, 1'b0);
        chk("rst_done", bus.tx_done, 1'b0);
        rst          = 1'b0;
        bus.tx_valid = 1'b0;
        idle_check(3);
        start(8'hA5);
        check_frame(8'hA5, 1'b0);
        idle_check(1);
        start(8'h07);
        check_frame(8'h07, 1'b0);
        @(negedge clk);
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_data = 8'hFF;
        check_frame(8'h00, 1'b0);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        check_frame(8'hFF, 1'b0);
        idle_check(2);
        r = 8'($urandom);
        start(r);
        check_frame(r, 1'b1);
        idle_check(2 * B);
        repeat (6) begin
            r = 8'($urandom);
            start(r);
            check_frame(r, 1'b0);
        end
        repeat (3) begin
            r = 8'($urandom);
            s = 8'($urandom);
            @(negedge clk);
            bus.tx_data  = r;
            bus.tx_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.tx_data = s;
            check_frame(r, 1'b0);
            @(posedge clk);
            #1;
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'($urandom);
            check_frame(s, 1'b0);
        end
        start(8'hC3);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_line", bus.tx_line, 1'b1);
        chk("midrst_ready", bus.tx_ready, 1'b1);
        chk("midrst_busy", bus.tx_busy, 1'b0);
        chk("midrst_done", bus.tx_done, 1'b0);
        idle_check(NB * B);
        start(8'h3C);
        check_frame(8'h3C, 1'b0);
        idle_check(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
